wb_bus_if: RTL and testbench

- Parametrised bridge between one CPU memory port and a Wishbone B3 classic master bus.
- The CPU port is the instruction-fetch or data port (ce/we/sel/addr/data).
- Replaces direct ROM/RAM wiring so the core can sit in an SoC with a bus interconnect.
- Converts single-cycle CPU accesses into multi-cycle bus cycles and raises a stall request toward stall_ctrl until each access completes.
- Adds bus-error and timeout handling, a flush abort, and a selectable pipeline stall bit.

---
 rtl/wb_bus_if_pkg.sv | 15 +
 rtl/wb_bus_if.sv | 179 +++++++++++++++++
 tb/tb_wb_bus_if.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_bus_if_pkg.sv
// Shared definitions for the CPU-port to Wishbone B3 classic bridge:
// FSM encodings and the pipeline stall-vector constants.
package wb_bus_if_pkg;

    localparam int STALL_BUS_W   = 6;
    localparam int STALL_IDX_IF  = 1;
    localparam int STALL_IDX_MEM = 3;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        BUSY       = 2'b01,
        WAIT_STALL = 2'b11
    } wb_state_e;

endpackage

// File: rtl/wb_bus_if.sv
// Bridge from one CPU memory port (IF or MEM) to a Wishbone B3 classic master.
// Holds the pipeline with stallreq_o until the bus cycle ends, then delivers read data once.
module wb_bus_if
    import wb_bus_if_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int SELW      = DW / 8,
    parameter int STALL_W   = STALL_BUS_W,
    parameter int STALL_IDX = STALL_IDX_IF,
    parameter int TIMEOUT   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               flush_i,
    input  logic               cpu_ce_i,
    input  logic               cpu_we_i,
    input  logic [AW-1:0]      cpu_addr_i,
    input  logic [SELW-1:0]    cpu_sel_i,
    input  logic [DW-1:0]      cpu_data_i,
    output logic [DW-1:0]      cpu_data_o,
    output logic               stallreq_o,
    output logic               bus_err_o,
    input  logic [DW-1:0]      wb_data_i,
    input  logic               wb_ack_i,
    input  logic               wb_err_i,
    output logic [AW-1:0]      wb_addr_o,
    output logic [DW-1:0]      wb_data_o,
    output logic               wb_we_o,
    output logic [SELW-1:0]    wb_sel_o,
    output logic               wb_stb_o,
    output logic               wb_cyc_o
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    wb_state_e         state_q, state_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     data_q, data_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic [DW-1:0]     rd_buf_q, rd_buf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bus_err_q, bus_err_d;

    logic              stall_bit_s;
    logic              timeout_s;
    logic              err_hit_s;
    logic              unused_stall_s;

    assign stall_bit_s    = stall_i[STALL_IDX];
    assign unused_stall_s = ^stall_i;
    assign err_hit_s      = wb_err_i | timeout_s;

    // Timeout fires on the last allowed BUSY cycle; disabled entirely when TIMEOUT is 0.
    always_comb begin
        if (TIMEOUT > 0) begin
            timeout_s = (state_q == BUSY) && (cnt_q == CNT_W'(TIMEOUT - 1));
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Next-state, next-register and combinational CPU-side outputs.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        we_d       = we_q;
        addr_d     = addr_q;
        data_d     = data_q;
        sel_d      = sel_q;
        rd_buf_d   = rd_buf_q;
        cnt_d      = cnt_q;
        bus_err_d  = 1'b0;
        stallreq_o = 1'b0;
        cpu_data_o = {DW{1'b0}};

        case (state_q)
            IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    stallreq_o = 1'b1;
                    addr_d     = cpu_addr_i;
                    data_d     = cpu_data_i;
                    sel_d      = cpu_sel_i;
                    we_d       = cpu_we_i;
                    cyc_d      = 1'b1;
                    stb_d      = 1'b1;
                    cnt_d      = {CNT_W{1'b0}};
                    state_d    = BUSY;
                end else begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    we_d  = 1'b0;
                end
            end
            BUSY: begin
                stallreq_o = ~(wb_ack_i | err_hit_s);
                if (flush_i) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = IDLE;
                end else if (err_hit_s) begin
                    // err outranks a simultaneous ack; the stage sees zero data.
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    we_d      = 1'b0;
                    bus_err_d = 1'b1;
                    rd_buf_d  = {DW{1'b0}};
                    state_d   = stall_bit_s ? WAIT_STALL : IDLE;
                end else if (wb_ack_i) begin
                    cyc_d      = 1'b0;
                    stb_d      = 1'b0;
                    we_d       = 1'b0;
                    rd_buf_d   = we_q ? {DW{1'b0}} : wb_data_i;
                    cpu_data_o = we_q ? {DW{1'b0}} : wb_data_i;
                    state_d    = stall_bit_s ? WAIT_STALL : IDLE;
                end else begin
                    cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            WAIT_STALL: begin
                // Another requester still freezes the pipe; keep presenting the captured word.
                cpu_data_o = rd_buf_q;
                if (!stall_bit_s || flush_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_STALL;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    // State and registered Wishbone outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= {AW{1'b0}};
            data_q    <= {DW{1'b0}};
            sel_q     <= {SELW{1'b0}};
            rd_buf_q  <= {DW{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            sel_q     <= sel_d;
            rd_buf_q  <= rd_buf_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = stb_q;
    assign wb_we_o   = we_q;
    assign wb_addr_o = addr_q;
    assign wb_data_o = data_q;
    assign wb_sel_o  = sel_q;
    assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_wb_bus_if.sv
// Directed bench for wb_bus_if: stimulus pushes one expected record per bus cycle,
// a monitor pops it when wb_cyc_o falls; cycle-level details are checked inline.
module tb_wb_bus_if;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall_i = 6'd0;
    logic        flush_i = 1'b0;
    logic        cpu_ce_i = 1'b0;
    logic        cpu_we_i = 1'b0;
    logic [31:0] cpu_addr_i = 32'd0;
    logic [3:0]  cpu_sel_i = 4'd0;
    logic [31:0] cpu_data_i = 32'd0;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic        bus_err_o;
    logic [31:0] wb_data_i = 32'd0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;

    wb_bus_if #(.DW(32), .AW(32), .STALL_W(6), .STALL_IDX(1), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
        .stallreq_o(stallreq_o), .bus_err_o(bus_err_o),
        .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        logic [31:0] data;
        logic        stall;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int len, input logic [31:0] data, input logic stall, input logic err);
        exp_t e;
        e.len = len; e.data = data; e.stall = stall; e.err = err;
        sb_q.push_back(e);
    endtask

    // Monitor: track each bus cycle and compare its ending against the scoreboard.
    bit          in_cyc = 1'b0;
    int          cyc_len = 0;
    logic [31:0] last_data;
    logic        last_stall;
    always @(negedge clk) begin
        if (rst) begin
            in_cyc = 1'b0;
        end else if (wb_cyc_o) begin
            if (!in_cyc) begin
                in_cyc  = 1'b1;
                cyc_len = 0;
            end
            cyc_len++;
            last_data  = cpu_data_o;
            last_stall = stallreq_o;
        end else if (in_cyc) begin
            exp_t e;
            in_cyc = 1'b0;
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_pop: got unexpected bus cycle expected none at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                chk("sb_len", 32'(cyc_len), 32'(e.len));
                chk("sb_data", last_data, e.data);
                chk("sb_stallreq_last", {31'd0, last_stall}, {31'd0, e.stall});
                chk("sb_bus_err", {31'd0, bus_err_o}, {31'd0, e.err});
                chk("sb_stb_low", {31'd0, wb_stb_o}, 32'd0);
            end
        end
    end

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("rst_addr", wb_addr_o, 32'd0);
        chk("rst_data", wb_data_o, 32'd0);
        chk("rst_sel", {28'd0, wb_sel_o}, 32'd0);
        chk("rst_err", {31'd0, bus_err_o}, 32'd0);
        chk("rst_cpu_data", cpu_data_o, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Zero-wait read
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h100; cpu_sel_i = 4'hF;
        push(1, 32'hDEADBEEF, 1'b0, 1'b0);
        #1;
        chk("t1_idle_stallreq", {31'd0, stallreq_o}, 32'd1);
        chk("t1_idle_data", cpu_data_o, 32'd0);
        tick();
        cpu_ce_i = 1'b0; wb_ack_i = 1'b1; wb_data_i = 32'hDEADBEEF;
        #1;
        chk("t1_cyc", {31'd0, wb_cyc_o}, 32'd1);
        chk("t1_addr", wb_addr_o, 32'h100);
        chk("t1_data", cpu_data_o, 32'hDEADBEEF);
        chk("t1_stallreq", {31'd0, stallreq_o}, 32'd0);
        tick();
        wb_ack_i = 1'b0; wb_data_i = 32'd0;
        #1;
        chk("t1_cyc_done", {31'd0, wb_cyc_o}, 32'd0);
        chk("t1_data_after", cpu_data_o, 32'd0);
        tick();

        // Write with 3 wait states; cpu inputs wiggle during BUSY and must be ignored
        cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h200; cpu_sel_i = 4'b0011;
        cpu_data_i = 32'h1234;
        push(4, 32'd0, 1'b0, 1'b0);
        tick();
        cpu_addr_i = 32'h9999; cpu_data_i = 32'hFFFF_FFFF; cpu_sel_i = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_wdata", wb_data_o, 32'h1234);
            chk("t2_sel", {28'd0, wb_sel_o}, 32'd3);
            chk("t2_addr", wb_addr_o, 32'h200);
            chk("t2_we", {31'd0, wb_we_o}, 32'd1);
            chk("t2_stallreq", {31'd0, stallreq_o}, 32'd1);
            tick();
        end
        cpu_ce_i = 1'b0; wb_ack_i = 1'b1; wb_data_i = 32'h0;
        #1;
        chk("t2_ack_wdata", wb_data_o, 32'h1234);
        chk("t2_ack_stallreq", {31'd0, stallreq_o}, 32'd0);
        tick();
        wb_ack_i = 1'b0;
        #1;
        chk("t2_we_drop", {31'd0, wb_we_o}, 32'd0);
        chk("t2_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
        chk("t2_cpu_data", cpu_data_o, 32'd0);
        tick();

        // Read acked while stall bit 1 is held by another requester
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h300;
        push(1, 32'hA5A5A5A5, 1'b0, 1'b0);
        tick();
        wb_ack_i = 1'b1; wb_data_i = 32'hA5A5A5A5; stall_i = 6'b000010;
        tick();
        wb_ack_i = 1'b0; wb_data_i = 32'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_hold_data", cpu_data_o, 32'hA5A5A5A5);
            chk("t3_hold_stallreq", {31'd0, stallreq_o}, 32'd0);
            chk("t3_hold_no_cyc", {31'd0, wb_cyc_o}, 32'd0);
            if (i == 2) begin
                stall_i = 6'd0; cpu_ce_i = 1'b0;
            end
            tick();
        end
        #1;
        chk("t3_idle_data", cpu_data_o, 32'd0);
        chk("t3_idle_cyc", {31'd0, wb_cyc_o}, 32'd0);
        tick();

        // Flush in the second BUSY cycle; a late ack afterwards is ignored
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h400;
        push(2, 32'd0, 1'b1, 1'b0);
        tick();
        cpu_ce_i = 1'b0;
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0; wb_ack_i = 1'b1; wb_data_i = 32'h55;
        #1;
        chk("t4_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
        chk("t4_late_data", cpu_data_o, 32'd0);
        chk("t4_stallreq", {31'd0, stallreq_o}, 32'd0);
        tick();
        wb_ack_i = 1'b0; wb_data_i = 32'd0;
        #1;
        chk("t4_no_err", {31'd0, bus_err_o}, 32'd0);
        chk("t4_still_idle", {31'd0, wb_cyc_o}, 32'd0);
        tick();

        // err and ack together while stalled: error wins and the held word is zero
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h500;
        push(1, 32'd0, 1'b0, 1'b1);
        tick();
        cpu_ce_i = 1'b0; wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_data_i = 32'h77;
        stall_i = 6'b000010;
        #1;
        chk("t5_stallreq", {31'd0, stallreq_o}, 32'd0);
        chk("t5_data", cpu_data_o, 32'd0);
        tick();
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_data_i = 32'd0; stall_i = 6'd0;
        #1;
        chk("t5_err_pulse", {31'd0, bus_err_o}, 32'd1);
        chk("t5_rd_buf_zero", cpu_data_o, 32'd0);
        tick();
        #1;
        chk("t5_err_single", {31'd0, bus_err_o}, 32'd0);
        tick();

        // Timeout: no ack for 8 BUSY cycles
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h600;
        push(8, 32'd0, 1'b0, 1'b1);
        tick();
        cpu_ce_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t6_cyc", {31'd0, wb_cyc_o}, 32'd1);
            chk("t6_stallreq", {31'd0, stallreq_o}, (i == 7) ? 32'd0 : 32'd1);
            tick();
        end
        #1;
        chk("t6_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
        chk("t6_err_pulse", {31'd0, bus_err_o}, 32'd1);
        tick();

        // Asynchronous reset in the middle of a write
        cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h700; cpu_data_i = 32'hFFFF;
        cpu_sel_i = 4'hF;
        tick();
        cpu_ce_i = 1'b0;
        chk("t7_cyc_before", {31'd0, wb_cyc_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t7_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("t7_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("t7_we", {31'd0, wb_we_o}, 32'd0);
        chk("t7_addr", wb_addr_o, 32'd0);
        chk("t7_wdata", wb_data_o, 32'd0);
        chk("t7_sel", {28'd0, wb_sel_o}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Recovery read after reset
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h800;
        push(1, 32'h0BADF00D, 1'b0, 1'b0);
        tick();
        cpu_ce_i = 1'b0; wb_ack_i = 1'b1; wb_data_i = 32'h0BADF00D;
        #1;
        chk("t8_data", cpu_data_o, 32'h0BADF00D);
        tick();
        wb_ack_i = 1'b0; wb_data_i = 32'd0;
        repeat (3) tick();

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
